wb_cmd_master: RTL and testbench
================================

# wb_cmd_master

Wishbone classic-cycle initiator that turns single-word commands from a valid/ready command port into bus transactions toward the user-area slaves (BRAM window 0x380xxxxx, UART window 0x300xxxxx), then returns read data or a timeout error on a valid/ready response port. It sits on the master side of the user-project Wishbone bus. It is used for self-test and DMA-style sequencers that must talk to the same slaves the management SoC reaches. One transaction is outstanding at a time, and a bounded ack-wait timer prevents a hung slave from stalling the sequencer.

## Interface
- TIMEOUT, 64: max cycles stb is held without ack before abort; legal range 2..65535.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on the edge where cmd_valid & cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_sel  in  4  byte lane selects.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed on the edge where rsp_valid & rsp_ready.
- rsp_dat  out  32  read data; 0 for writes and for timeouts.
- rsp_err  out  1  1 = transaction timed out.
- wbm_cyc_o, wbm_stb_o  out  1 each  Wishbone cycle/strobe; always equal.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  lane selects.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  slave read data.
- busy  out  1  state != IDLE.
- err_count  out  16  timeouts since reset; saturates at 0xFFFF.

## Operation
- FSM states are IDLE, BUS and RSP. Reset enters IDLE.
- IDLE:
  - cmd_ready = 1.
  - On accept: latch we/sel/adr/dat into the wbm_* output registers, clear the timer, go to BUS.
- BUS:
  - wbm_cyc_o = wbm_stb_o = 1. we/sel/adr/dat are held constant for the whole cycle.
  - If wbm_ack_i = 1: rsp_dat ← (we ? 0 : wbm_dat_i), rsp_err ← 0, go to RSP.
  - Else if timer == TIMEOUT-1: rsp_dat ← 0, rsp_err ← 1, err_count += 1 (saturating), go to RSP.
  - Else timer += 1.
- RSP:
  - rsp_valid = 1, cyc/stb = 0.
  - On rsp_ready, go to IDLE. rsp_dat and rsp_err hold until consumed.
- cmd_ready is 0 in BUS and RSP. cmd_* inputs are ignored there.
- wbm_ack_i outside BUS is ignored.
- If ack arrives on the same cycle the timer reaches TIMEOUT-1, ack wins: normal response, no error.
- Address, sel and data pass through unmodified; no decoding or alignment check in this block.
- Timer width is 16 bits.

## Timing
- Reset values: cmd_ready 0 during rst, 1 in the first cycle after; rsp_valid 0, rsp_dat 0, rsp_err 0, all wbm_* outputs 0, busy 0, err_count 0.
- Accept at edge N: cyc/stb high in cycle N+1 (registered, no combinational path from cmd_* to wbm_*).
- Ack sampled high at edge M: cyc/stb low in cycle M+1, rsp_valid high in cycle M+1.
- Zero-wait slave (ack in the first stb cycle): stb is high for exactly 1 cycle.
- With rsp_ready tied high, the next cmd_ready occurs at N+3. Peak throughput is one transaction per 3 cycles.
- Timeout: with no ack, stb is high for exactly TIMEOUT cycles, then rsp_valid rises the next cycle.
- Back-pressure: rsp_valid and rsp data are stable until rsp_ready. No new bus cycle starts while a response is pending.
- Reset mid-BUS: cyc/stb drop in the cycle after the rst edge, the response is discarded, and err_count clears.

## Test plan
- Read, slave ack after 12 stb cycles returning 0x1234_5678 at 0x3800_0010:
  - stb high exactly 12 cycles with adr 0x3800_0010, we 0;
  - then rsp_valid with rsp_dat 0x1234_5678, rsp_err 0.
- Write 0xA5A5_0F0F, sel 0xF, to 0x3000_0004 with zero-wait ack:
  - wbm_dat_o/we/sel are stable for 1 stb cycle;
  - rsp_dat 0, rsp_err 0;
  - cmd_ready returns 3 cycles after accept with rsp_ready tied high.
- TIMEOUT=8, slave never acks:
  - stb high exactly 8 cycles;
  - rsp_err 1, rsp_dat 0, err_count 1;
  - a second timeout makes err_count 2.
- TIMEOUT=8, ack on the 8th stb cycle: normal response, rsp_err 0, err_count unchanged.
- rsp_ready held low 5 cycles after a read:
  - rsp_valid/rsp_dat are stable and cmd_ready stays 0;
  - a cmd_valid held high is not accepted until the cycle after rsp_ready.
- Assert rst for 1 cycle during the 3rd stb cycle of a read:
  - cyc/stb are 0 next cycle, no rsp_valid ever follows;
  - cmd_ready is 1 the cycle after rst deasserts.

Source files
------------

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone classic-cycle initiator.
// Accepts one command on a valid/ready port, runs it on the bus with a
// bounded ack wait, and returns read data or a timeout flag on a
// valid/ready response port.
//
// Handshake: a transfer happens on the rising edge where valid & ready are
// both high; the producer holds valid and its payload steady until then,
// and ready never depends on valid.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy,
  output logic [15:0] err_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] timer;
  logic        accept;
  logic        ack_hit;
  logic        tmo_hit;

  // Next-state logic; ack takes priority over the timeout on the same cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ack_hit    = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          ack_hit    = 1'b1;
          state_next = RSP;
        end else if (timer == TIMEOUT_LAST) begin
          tmo_hit    = 1'b1;
          state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Bus request registers: captured at accept, held through the bus cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
    end else if (accept) begin
      wbm_we_o  <= cmd_we;
      wbm_sel_o <= cmd_sel;
      wbm_adr_o <= cmd_adr;
      wbm_dat_o <= cmd_dat;
    end
  end

  // Ack-wait timer: zeroed at accept, counts stb cycles without ack.
  always_ff @(posedge clk) begin
    if (rst)                                     timer <= 16'h0;
    else if (accept)                             timer <= 16'h0;
    else if (state == BUS && !ack_hit && !tmo_hit) timer <= timer + 16'h1;
  end

  // Response registers: loaded when the bus cycle ends, held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_dat <= 32'h0;
      rsp_err <= 1'b0;
    end else if (ack_hit) begin
      rsp_dat <= wbm_we_o ? 32'h0 : wbm_dat_i;
      rsp_err <= 1'b0;
    end else if (tmo_hit) begin
      rsp_dat <= 32'h0;
      rsp_err <= 1'b1;
    end
  end

  // Saturating timeout counter.
  always_ff @(posedge clk) begin
    if (rst)                                   err_count <= 16'h0;
    else if (tmo_hit && err_count != 16'hFFFF) err_count <= err_count + 16'h1;
  end

  // Decoded outputs; all derive from registered state only (cmd_ready also
  // drops while rst is asserted).
  always_comb begin
    cmd_ready = (state == IDLE) && !rst;
    wbm_cyc_o = (state == BUS);
    wbm_stb_o = (state == BUS);
    rsp_valid = (state == RSP);
    busy      = (state != IDLE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master: directed transaction table, a few random
// transactions, back-pressure and mid-cycle reset sequences. Inputs change
// and outputs are sampled on the falling clock edge.
module tb_wb_cmd_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy;
  logic [15:0] err_count;
  logic [1:0]  state_dbg;

  wb_cmd_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .busy(busy), .err_count(err_count), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdata;    // slave read data returned with ack
    int          ack_at;   // stb cycle carrying ack; 0 = slave never acks
    int          hold;     // cycles rsp_ready is held low
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_stb;
  } vec_t;

  vec_t        vecs[7];
  logic [32:0] exp_q[$];   // {rsp_err, rsp_dat}
  logic [15:0] err_exp;
  int          n_cmp;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one command, plays the slave, applies back-pressure, consumes.
  task automatic run_txn(input vec_t v);
    int          guard;
    int          stb_cnt;
    int          lat;
    logic [32:0] exp;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_before_cmd", {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_sel   = v.sel;
    cmd_adr   = v.adr;
    cmd_dat   = v.dat;
    exp_q.push_back({v.exp_err, v.exp_dat});
    if (v.exp_err && err_exp != 16'hFFFF) err_exp = err_exp + 16'h1;
    @(negedge clk);
    // Scramble command inputs: the bus request must stay as captured.
    cmd_valid = 1'b0;
    cmd_we    = ~v.we;
    cmd_sel   = ~v.sel;
    cmd_adr   = ~v.adr;
    cmd_dat   = ~v.dat;
    lat     = 1;
    stb_cnt = 0;
    guard   = 0;
    if (!wbm_stb_o) check("stb_first_cycle", 32'h0, 32'h1);
    while (!rsp_valid && guard < 200) begin
      if (wbm_stb_o) begin
        stb_cnt++;
        check("cyc_eq_stb", {31'h0, wbm_cyc_o}, 32'h1);
        check("busy_in_bus", {31'h0, busy}, 32'h1);
        check("cmd_ready_in_bus", {31'h0, cmd_ready}, 32'h0);
        check("wbm_adr", wbm_adr_o, v.adr);
        check("wbm_we", {31'h0, wbm_we_o}, {31'h0, v.we});
        check("wbm_sel", {28'h0, wbm_sel_o}, {28'h0, v.sel});
        check("wbm_dat", wbm_dat_o, v.dat);
        if (v.ack_at != 0 && stb_cnt == v.ack_at) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = v.rdata;
        end else begin
          wbm_ack_i = 1'b0;
          wbm_dat_i = $urandom;
        end
      end else begin
        wbm_ack_i = 1'b0;
      end
      @(negedge clk);
      lat++;
      guard++;
    end
    wbm_ack_i = 1'b0;
    check("rsp_valid_seen", {31'h0, rsp_valid}, 32'h1);
    check("stb_cycles", stb_cnt, v.exp_stb);
    check("stb_low_in_rsp", {31'h0, wbm_stb_o}, 32'h0);
    exp = exp_q[0];
    // Back-pressure: response stable, stray ack and new command ignored.
    for (int i = 0; i < v.hold; i++) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_adr   = $urandom;
      wbm_ack_i = 1'b1;
      wbm_dat_i = $urandom;
      @(negedge clk);
      lat++;
      check("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("hold_rsp_dat", rsp_dat, exp[31:0]);
      check("hold_rsp_err", {31'h0, rsp_err}, {31'h0, exp[32]});
      check("hold_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      check("hold_no_stb", {31'h0, wbm_stb_o}, 32'h0);
    end
    wbm_ack_i = 1'b0;
    exp = exp_q.pop_front();
    check("rsp_dat", rsp_dat, exp[31:0]);
    check("rsp_err", {31'h0, rsp_err}, {31'h0, exp[32]});
    rsp_ready = 1'b1;
    @(negedge clk);
    lat++;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("no_accept_at_consume", {31'h0, wbm_stb_o}, 32'h0);
    check("rsp_valid_dropped", {31'h0, rsp_valid}, 32'h0);
    check("cmd_ready_latency", lat, v.exp_stb + 2 + v.hold);
    check("cmd_ready_after", {31'h0, cmd_ready}, 32'h1);
    check("err_count", {16'h0, err_count}, {16'h0, err_exp});
  endtask

  initial begin
    vec_t r;
    int   guard;
    int   stb_cnt;
    logic saw_rsp;
    n_cmp     = 0;
    n_fail    = 0;
    err_exp   = 16'h0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_sel   = 4'h0;
    cmd_adr   = 32'h0;
    cmd_dat   = 32'h0;
    rsp_ready = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;

    //             we    sel    adr            dat            rdata          ack  hold exp_dat        err   stb
    vecs[0] = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,         32'h1234_5678, 12,  0, 32'h1234_5678, 1'b0, 12};
    vecs[1] = '{1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_0F0F, 32'hDEAD_BEEF, 1,   0, 32'h0,         1'b0, 1};
    vecs[2] = '{1'b0, 4'hF, 32'h3800_0020, 32'h0,         32'h1111_1111, 0,   0, 32'h0,         1'b1, TO};
    vecs[3] = '{1'b1, 4'h3, 32'h3000_0008, 32'h5555_AAAA, 32'h2222_2222, 0,   2, 32'h0,         1'b1, TO};
    vecs[4] = '{1'b0, 4'hF, 32'h3800_0030, 32'h0,         32'hCAFE_F00D, TO,  0, 32'hCAFE_F00D, 1'b0, TO};
    vecs[5] = '{1'b0, 4'h3, 32'h3800_0100, 32'h0,         32'h0BAD_F00D, 3,   5, 32'h0BAD_F00D, 1'b0, 3};
    vecs[6] = '{1'b1, 4'h5, 32'h3000_000C, 32'h0F0F_1234, 32'h7777_7777, 2,   1, 32'h0,         1'b0, 2};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_dat", rsp_dat, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_cyc_stb", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
    check("rst_wbm_we_sel", {27'h0, wbm_we_o, wbm_sel_o}, 32'h0);
    check("rst_wbm_adr", wbm_adr_o, 32'h0);
    check("rst_wbm_dat", wbm_dat_o, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_err_count", {16'h0, err_count}, 32'h0);
    rst = 1'b0;
    #1;
    check("cmd_ready_after_rst", {31'h0, cmd_ready}, 32'h1);
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Random transactions
    for (int i = 0; i < 6; i++) begin
      r.we     = 1'($urandom_range(0, 1));
      r.sel    = 4'($urandom_range(0, 15));
      r.adr    = ($urandom_range(0, 1) != 0) ? (32'h3800_0000 | 32'($urandom_range(0, 255) * 4))
                                            : (32'h3000_0000 | 32'($urandom_range(0, 255) * 4));
      r.dat    = $urandom;
      r.rdata  = $urandom;
      r.ack_at = $urandom_range(0, 5);
      r.hold   = $urandom_range(0, 3);
      r.exp_err = (r.ack_at == 0);
      r.exp_dat = (r.exp_err || r.we) ? 32'h0 : r.rdata;
      r.exp_stb = r.exp_err ? TO : r.ack_at;
      run_txn(r);
    end

    // Reset during the 3rd stb cycle of a read: response discarded
    check("err_count_before_rst", {31'h0, (err_count != 16'h0)}, 32'h1);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_sel   = 4'hF;
    cmd_adr   = 32'h3800_0040;
    cmd_dat   = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    stb_cnt = 0;
    guard   = 0;
    while (stb_cnt < 3 && guard < 20) begin
      if (wbm_stb_o) stb_cnt++;
      if (stb_cnt < 3) @(negedge clk);
      guard++;
    end
    check("stb_reached_3", stb_cnt, 3);
    rst = 1'b1;
    wbm_ack_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    err_exp = 16'h0;
    #1;
    check("midrst_cyc_stb", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
    check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("midrst_err_count", {16'h0, err_count}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    saw_rsp = 1'b0;
    for (int i = 0; i < TO + 8; i++) begin
      @(negedge clk);
      wbm_ack_i = 1'b1;
      if (rsp_valid || wbm_stb_o) saw_rsp = 1'b1;
    end
    wbm_ack_i = 1'b0;
    check("no_rsp_after_rst", {31'h0, saw_rsp}, 32'h0);

    // Recovery transaction after reset
    run_txn(vecs[0]);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
